// File: rtl/subtract_arbiter.sv
// Round-robin arbiter sharing one 12-bit subtract unit among NUM_REQ requesters.
// Operands are latched on grant; result, overflow and winner ID are returned one cycle later.

module sub12 (
  input  logic [11:0] lhs,
  input  logic [11:0] rhs,
  output logic [11:0] diff,
  output logic        borrow
);
  logic [12:0] wide;

  assign wide   = {1'b0, lhs} - {1'b0, rhs};
  assign diff   = wide[11:0];
  assign borrow = wide[12];
endmodule

// state | meaning
// IDLE  | waiting for a request; may issue a grant on the next edge
// EXEC  | operands latched; result presented with done on the next edge
module subtract_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [12*NUM_REQ-1:0] lhs_bus,
  input  logic [12*NUM_REQ-1:0] rhs_bus,
  output logic [NUM_REQ-1:0]    grant,
  output logic                  busy,
  output logic                  done,
  output logic [ID_W-1:0]       done_id,
  output logic [11:0]           result,
  output logic                  overflow
);
  typedef enum logic {IDLE, EXEC} state_t;

  localparam logic [ID_W:0] NUM_REQ_W = (ID_W+1)'(NUM_REQ);

  state_t                 state, state_nxt;
  logic [ID_W-1:0]        last, id_q, win, off;
  logic [ID_W:0]          pos;
  logic [11:0]            lhs_q, rhs_q, sel_lhs, sel_rhs, diff;
  logic                   borrow, any_req;
  logic [2*NUM_REQ-1:0]   req_dbl;
  logic [NUM_REQ-1:0]     req_rot;

  // Rotate so that bit 0 of req_rot is the requester just after the last winner.
  assign req_dbl = {req, req};
  assign req_rot = req_dbl[({1'b0, last} + 1'b1) +: NUM_REQ];

  always_comb begin
    off     = '0;
    any_req = 1'b0;
    for (int j = NUM_REQ-1; j >= 0; j--) begin
      if (req_rot[j]) begin
        any_req = 1'b1;
        off     = ID_W'(j);
      end
    end
    pos = {1'b0, last} + {1'b0, off} + 1'b1;
    if (pos >= NUM_REQ_W) pos = pos - NUM_REQ_W;
    win = pos[ID_W-1:0];
  end

  always_comb begin
    sel_lhs = '0;
    sel_rhs = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (win == ID_W'(j)) begin
        sel_lhs = lhs_bus[12*j +: 12];
        sel_rhs = rhs_bus[12*j +: 12];
      end
    end
  end

  sub12 u_sub (
    .lhs    (lhs_q),
    .rhs    (rhs_q),
    .diff   (diff),
    .borrow (borrow)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = EXEC;
      EXEC:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      last     <= ID_W'(NUM_REQ-1);
      id_q     <= '0;
      lhs_q    <= '0;
      rhs_q    <= '0;
      grant    <= '0;
      done     <= 1'b0;
      done_id  <= '0;
      result   <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      grant <= '0;
      done  <= 1'b0;
      if (state == IDLE) begin
        if (any_req) begin
          grant <= NUM_REQ'(1) << win;
          lhs_q <= sel_lhs;
          rhs_q <= sel_rhs;
          id_q  <= win;
          last  <= win;
        end
      end else begin
        result   <= diff;
        overflow <= borrow;
        done     <= 1'b1;
        done_id  <= id_q;
      end
    end
  end

  assign busy = (state == EXEC);
endmodule

// File: doc/subtract_arbiter.md
Name: subtract_arbiter

Overview:
- Shares one 12-bit unsigned subtract unit among NUM_REQ requesters, e.g. per-voice envelope and pitch-step logic in the synth.
- Round-robin arbitration with a req/grant/done handshake.
- Operands are latched on grant. Result and overflow are registered and returned with the winner's ID one cycle later.
- Internally it instantiates the team's 12-bit subtract unit: result = lhs - rhs mod 4096, overflow = (lhs < rhs) unsigned.

Parameters:
- NUM_REQ, default 4: number of requesters. Legal range 2..8.
- ID_W, default 2: width of done_id. Must equal ceil(log2(NUM_REQ)).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  per-requester request level.
- lhs_bus  input  12*NUM_REQ  minuend of requester i at bits [12*i+11:12*i].
- rhs_bus  input  12*NUM_REQ  subtrahend of requester i, same packing.
- grant  output  NUM_REQ  one-hot, 1-cycle pulse; the operands of that requester were captured.
- busy  output  1  high while state = EXEC.
- done  output  1  1-cycle pulse; result, overflow and done_id are valid.
- done_id  output  ID_W  index of the requester whose result is presented.
- result  output  12  lhs - rhs modulo 4096; held until the next done.
- overflow  output  1  1 when lhs < rhs; held with result.

Behaviour:
- Reset values (synchronous, active-high):
  - grant = 0, busy = 0, done = 0, done_id = 0, result = 0, overflow = 0.
  - State = IDLE; operand registers = 0.
  - Round-robin pointer last = NUM_REQ-1, so requester 0 has first priority.
- State IDLE, no req bit set: stay in IDLE; all pulse outputs are 0.
- State IDLE, any req bit set:
  - Winner = first index with req set, searching from (last+1) mod NUM_REQ upward and wrapping.
  - Next edge: grant[winner] = 1; lhs_q/rhs_q <= winner's operand slices; id_q <= winner; last <= winner; state <= EXEC; busy = 1.
- State EXEC:
  - req is ignored.
  - Next edge: result <= lhs_q - rhs_q (12-bit wrap), overflow <= (lhs_q < rhs_q), done <= 1, done_id <= id_q.
  - State <= IDLE; grant = 0; busy = 0.
- Latency: req sampled at edge E produces grant at E+1 and done at E+2.
- Throughput: at most one operation per 2 cycles. The IDLE cycle that shows done may already sample req and issue the next grant.
- Requester rules:
  - Hold req and operands stable until grant is seen.
  - Deassert req in the cycle after grant. If req is still high when IDLE samples, it counts as a new request.
  - Deasserting req before grant withdraws the request; this is legal and no grant follows.
- Simultaneous requests: exactly one grant; the others wait. No requester waits more than NUM_REQ-1 operations while holding req.
- Operand changes after grant have no effect on the operation in flight.
- Boundary arithmetic:
  - lhs = rhs gives result 0, overflow 0.
  - lhs = 0, rhs = 4095 gives result 1, overflow 1.
  - lhs = 4095, rhs = 0 gives result 4095, overflow 0.
- Reset asserted in EXEC: the operation is discarded, no done, and all values return to their reset values on that edge.
- req bits at or above NUM_REQ do not exist. No X may propagate to outputs after reset.

Test Plan:
- After rst, req=0001, lhs0=100, rhs0=30 -> grant=0001 at E+1; done at E+2 with done_id=0, result=70, overflow=0; busy high only in EXEC.
- req=0001, lhs0=5, rhs0=10 -> result=4091 (0xFFB), overflow=1. Then lhs0=4095, rhs0=4095 -> result=0, overflow=0.
- req=1111 held continuously, each requester dropping req the cycle after its grant and re-raising 1 cycle later -> grant order 0,1,2,3,0,... with a grant every 2 cycles; done_id follows the same order.
- Grant to req2, then lhs2 changed in the EXEC cycle -> result reflects the latched operands, not the new ones.
- rst pulsed during EXEC -> no done pulse; outputs are 0 next cycle; the next request with req=1000 is granted to requester 3 (pointer reset).
- req1 raised then dropped before grant while req3 is pending -> only requester 3 is granted; no grant ever to requester 1.
